// File: rtl/motor_ramp_sequencer.sv
// rtl/motor_ramp_sequencer.sv - duty ramp, dead-time reversal and emergency stop sequencer for the H-bridge stage
//
// Ports:
//   ACLK, ARESETN          clock (rising edge), asynchronous active-low reset
//   enable                 level; low ramps duty down to 0 and returns to idle
//   estop                  level; emergency stop, forces duty to 0, overrides all
//   cmd_valid              one-cycle strobe latching cmd_duty / cmd_dir
//   cmd_duty, cmd_dir      target duty and direction (1 = forward)
//   step                   duty change per ramp tick (0 freezes the ramp)
//   prescale               ramp tick period minus 1
//   duty, dir              applied duty and direction, registered
//   busy, at_target,       state decodes: RAMP|DEAD, HOLD, ESTOP
//   stopped
module motor_ramp_sequencer #(
    parameter int DUTY_W   = 8,
    parameter int PRESC_W  = 16,
    parameter int DEADTIME = 16
) (
    input  logic               ACLK,
    input  logic               ARESETN,
    input  logic               enable,
    input  logic               estop,
    input  logic               cmd_valid,
    input  logic [DUTY_W-1:0]  cmd_duty,
    input  logic               cmd_dir,
    input  logic [DUTY_W-1:0]  step,
    input  logic [PRESC_W-1:0] prescale,
    output logic [DUTY_W-1:0]  duty,
    output logic               dir,
    output logic               busy,
    output logic               at_target,
    output logic               stopped
);

    localparam int DEAD_W = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
    localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEADTIME - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RAMP  = 3'd1,
        ST_DEAD  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_ESTOP = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [DUTY_W-1:0]   duty_q, duty_d;
    logic                dir_q, dir_d;
    logic [DUTY_W-1:0]   tgt_duty_q;
    logic                tgt_dir_q;
    logic [PRESC_W-1:0]  presc_q, presc_d;
    logic [DEAD_W-1:0]   dead_q, dead_d;

    logic                rev_pending;
    logic [DUTY_W-1:0]   eff;
    logic                tick;
    logic [DUTY_W:0]     sum_ext;
    logic [DUTY_W:0]     diff_ext;
    logic [DUTY_W-1:0]   ramp_next;

    // Command registers load in every state so commands issued during an
    // emergency stop are honoured once it is released.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            tgt_duty_q <= '0;
            tgt_dir_q  <= 1'b0;
        end else if (cmd_valid) begin
            tgt_duty_q <= cmd_duty;
            tgt_dir_q  <= cmd_dir;
        end
    end

    assign rev_pending = (tgt_dir_q != dir_q);
    // A pending reversal or a disable both demand a ramp to zero first.
    assign eff         = (!enable || rev_pending) ? '0 : tgt_duty_q;
    // >= rather than == so a prescale reduced mid-count still ticks at once
    // instead of wrapping the whole counter range.
    assign tick        = (presc_q >= prescale);

    // One extra bit holds the carry/borrow so the clamp can never wrap.
    always_comb begin
        sum_ext   = {1'b0, duty_q} + {1'b0, step};
        diff_ext  = {1'b0, duty_q} - {1'b0, step};
        ramp_next = duty_q;
        if (duty_q < eff) begin
            ramp_next = (sum_ext > {1'b0, eff}) ? eff : sum_ext[DUTY_W-1:0];
        end else if (duty_q > eff) begin
            ramp_next = (diff_ext[DUTY_W] || (diff_ext < {1'b0, eff})) ? eff : diff_ext[DUTY_W-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        dir_d   = dir_q;
        presc_d = presc_q;
        dead_d  = dead_q;
        if (estop) begin
            state_d = ST_ESTOP;
            duty_d  = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    duty_d = '0;
                    if (enable && ((tgt_duty_q != '0) || rev_pending)) begin
                        state_d = ST_RAMP;
                        presc_d = '0;
                    end
                end
                ST_RAMP: begin
                    if ((duty_q == '0) && rev_pending && enable) begin
                        state_d = ST_DEAD;
                        dead_d  = '0;
                    end else if ((duty_q == '0) && !enable) begin
                        state_d = ST_IDLE;
                    end else if (duty_q == eff) begin
                        // Reached here with enable high and no reversal, so a
                        // zero target is a legitimate hold as well.
                        state_d = ST_HOLD;
                    end else begin
                        presc_d = tick ? '0 : presc_q + PRESC_W'(1);
                        if (tick) begin
                            duty_d = ramp_next;
                        end
                    end
                end
                ST_DEAD: begin
                    duty_d = '0;
                    if (dead_q == DEAD_LAST) begin
                        // Takes whatever direction is commanded now; a cancelled
                        // reversal leaves dir unchanged.
                        dir_d   = tgt_dir_q;
                        state_d = ST_RAMP;
                        presc_d = '0;
                    end else begin
                        dead_d = dead_q + DEAD_W'(1);
                    end
                end
                ST_HOLD: begin
                    // A hold at zero duty cannot see a reversal or disable through
                    // duty != eff, so those are tested explicitly and resolved in RAMP.
                    if ((duty_q != eff) || ((duty_q == '0) && (rev_pending || !enable))) begin
                        state_d = ST_RAMP;
                        presc_d = '0;
                    end
                end
                ST_ESTOP: begin
                    duty_d  = '0;
                    state_d = ST_IDLE;
                end
                default: begin
                    duty_d  = '0;
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q <= ST_IDLE;
            duty_q  <= '0;
            dir_q   <= 1'b0;
            presc_q <= '0;
            dead_q  <= '0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            dir_q   <= dir_d;
            presc_q <= presc_d;
            dead_q  <= dead_d;
        end
    end

    assign duty      = duty_q;
    assign dir       = dir_q;
    assign busy      = (state_q == ST_RAMP) || (state_q == ST_DEAD);
    assign at_target = (state_q == ST_HOLD);
    assign stopped   = (state_q == ST_ESTOP);

endmodule

// File: tb/tb_motor_ramp_sequencer.sv
// tb/tb_motor_ramp_sequencer.sv - self-checking bench for motor_ramp_sequencer
module tb_motor_ramp_sequencer;

    localparam int DW = 8;
    localparam int PW = 16;
    localparam int DT = 5;

    logic          ACLK = 1'b0;
    logic          ARESETN = 1'b1;
    logic          enable = 1'b0;
    logic          estop = 1'b0;
    logic          cmd_valid = 1'b0;
    logic [DW-1:0] cmd_duty = '0;
    logic          cmd_dir = 1'b0;
    logic [DW-1:0] step = '0;
    logic [PW-1:0] prescale = '0;
    logic [DW-1:0] duty;
    logic          dir;
    logic          busy;
    logic          at_target;
    logic          stopped;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic [DW-1:0] exp_q[$];
    int            chg_q[$];
    logic [DW-1:0] prev_duty = '0;
    logic [DW-1:0] mon_exp;

    motor_ramp_sequencer #(.DUTY_W(DW), .PRESC_W(PW), .DEADTIME(DT)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .enable(enable), .estop(estop),
        .cmd_valid(cmd_valid), .cmd_duty(cmd_duty), .cmd_dir(cmd_dir),
        .step(step), .prescale(prescale), .duty(duty), .dir(dir),
        .busy(busy), .at_target(at_target), .stopped(stopped)
    );

    always #5 ACLK = ~ACLK;
    always @(posedge ACLK) cyc++;

    // Scoreboard: every change of duty pops the next expected value.
    always @(posedge ACLK) begin
        #2;
        if (duty !== prev_duty) begin
            chg_q.push_back(cyc);
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL duty_unexpected: got %0d, no change expected (cycle %0d)", duty, cyc);
            end else begin
                mon_exp = exp_q.pop_front();
                if (duty !== mon_exp) begin
                    miscompares++;
                    $display("FAIL duty_seq: got %0d, expected %0d (cycle %0d)", duty, mon_exp, cyc);
                end
            end
            prev_duty = duty;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_cmd(input logic [DW-1:0] d, input logic dr);
        @(negedge ACLK);
        cmd_duty  = d;
        cmd_dir   = dr;
        cmd_valid = 1'b1;
        @(negedge ACLK);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge ACLK);
            n++;
        end
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout: %0d duty values still pending after %0d cycles", name, exp_q.size(), budget);
            exp_q.delete();
        end
    endtask

    task automatic wait_hold(input string name, input int budget);
        int n = 0;
        while (at_target !== 1'b1 && n < budget) begin
            @(negedge ACLK);
            n++;
        end
        vectors++;
        if (at_target !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_hold: at_target=%b, expected 1 within %0d cycles", name, at_target, budget);
        end
    endtask

    task automatic test_reset();
        #1 ARESETN = 1'b0;
        repeat (3) @(negedge ACLK);
        vectors++;
        if ({duty, dir, busy, at_target, stopped} !== {8'd0, 4'b0000}) begin
            miscompares++;
            $display("FAIL reset_outputs: duty=%0d dir=%b busy=%b at_target=%b stopped=%b, expected all 0",
                     duty, dir, busy, at_target, stopped);
        end
        ARESETN = 1'b1;
        @(negedge ACLK);
    endtask

    // Starting from dir=0, a forward command first passes the dead time, then
    // ramps 16 per tick with one tick every prescale+1 = 4 cycles.
    task automatic test_ramp_up();
        int bad = 0;
        step = 8'd16;
        prescale = 16'd3;
        enable = 1'b1;
        chg_q.delete();
        for (int v = 16; v <= 192; v += 16) exp_q.push_back(DW'(v));
        exp_q.push_back(8'd200);
        drive_cmd(8'd200, 1'b1);
        wait_drain("ramp_up", 400);
        vectors++;
        if (at_target !== 1'b0) begin
            miscompares++;
            $display("FAIL ramp_up_early_target: at_target=%b, expected 0 in cycle duty reaches 200", at_target);
        end
        @(negedge ACLK);
        vectors++;
        if (at_target !== 1'b1 || busy !== 1'b0 || duty !== 8'd200 || dir !== 1'b1) begin
            miscompares++;
            $display("FAIL ramp_up_hold: at_target=%b busy=%b duty=%0d dir=%b, expected 1 0 200 1",
                     at_target, busy, duty, dir);
        end
        for (int i = 1; i < chg_q.size(); i++) if (chg_q[i] - chg_q[i-1] != 4) bad++;
        vectors++;
        if (chg_q.size() != 13 || bad != 0) begin
            miscompares++;
            $display("FAIL ramp_up_interval: %0d updates, %0d intervals not 4 cycles, expected 13 and 0",
                     chg_q.size(), bad);
        end
    endtask

    task automatic test_ramp_down_clamp();
        step = 8'd64;
        exp_q.push_back(8'd136);
        exp_q.push_back(8'd72);
        exp_q.push_back(8'd10);
        drive_cmd(8'd10, 1'b1);
        wait_drain("ramp_down", 200);
        wait_hold("ramp_down", 10);
    endtask

    task automatic test_reversal();
        int n = 0;
        int cnt = 0;
        int bad = 0;
        step = 8'd100;
        exp_q.push_back(8'd100);
        drive_cmd(8'd100, 1'b1);
        wait_drain("rev_setup", 100);
        wait_hold("rev_setup", 10);
        step = 8'd50;
        exp_q.push_back(8'd50);
        exp_q.push_back(8'd0);
        exp_q.push_back(8'd50);
        drive_cmd(8'd50, 1'b0);
        while (duty !== 8'd0 && n < 100) begin
            @(negedge ACLK);
            n++;
        end
        // duty=0 in the last RAMP cycle, then DT cycles of DEAD, all with dir=1.
        while (dir === 1'b1 && cnt < 50) begin
            if (duty !== 8'd0 || busy !== 1'b1) bad++;
            cnt++;
            @(negedge ACLK);
        end
        vectors++;
        if (cnt != DT + 1 || bad != 0) begin
            miscompares++;
            $display("FAIL reversal_dead: %0d zero-duty cycles before dir flip (%0d bad), expected %0d (0 bad)",
                     cnt, bad, DT + 1);
        end
        vectors++;
        if (dir !== 1'b0) begin
            miscompares++;
            $display("FAIL reversal_dir: dir=%b, expected 0", dir);
        end
        wait_drain("reversal", 100);
        wait_hold("reversal", 10);
    endtask

    task automatic test_estop();
        prescale = 16'd0;
        step = 8'd10;
        exp_q.push_back(8'd60);
        exp_q.push_back(8'd70);
        exp_q.push_back(8'd80);
        drive_cmd(8'd200, 1'b0);
        wait_drain("estop_setup", 50);
        exp_q.push_back(8'd0);
        estop = 1'b1;
        @(negedge ACLK);
        vectors++;
        if (duty !== 8'd0 || stopped !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL estop_enter: duty=%0d stopped=%b busy=%b, expected 0 1 0", duty, stopped, busy);
        end
        drive_cmd(8'd30, 1'b0);
        vectors++;
        if (stopped !== 1'b1 || duty !== 8'd0) begin
            miscompares++;
            $display("FAIL estop_hold: stopped=%b duty=%0d, expected 1 0", stopped, duty);
        end
        exp_q.push_back(8'd10);
        exp_q.push_back(8'd20);
        exp_q.push_back(8'd30);
        estop = 1'b0;
        @(negedge ACLK);
        vectors++;
        if (stopped !== 1'b0 || busy !== 1'b0 || at_target !== 1'b0 || duty !== 8'd0) begin
            miscompares++;
            $display("FAIL estop_release_idle: stopped=%b busy=%b at_target=%b duty=%0d, expected 0 0 0 0",
                     stopped, busy, at_target, duty);
        end
        wait_drain("estop_restart", 50);
        wait_hold("estop_restart", 10);
    endtask

    task automatic test_enable_drop();
        step = 8'd90;
        exp_q.push_back(8'd120);
        drive_cmd(8'd120, 1'b0);
        wait_drain("enable_setup", 50);
        wait_hold("enable_setup", 10);
        step = 8'd40;
        exp_q.push_back(8'd80);
        exp_q.push_back(8'd40);
        exp_q.push_back(8'd0);
        enable = 1'b0;
        wait_drain("enable_drop", 50);
        @(negedge ACLK);
        vectors++;
        if (busy !== 1'b0 || at_target !== 1'b0 || duty !== 8'd0) begin
            miscompares++;
            $display("FAIL enable_idle: busy=%b at_target=%b duty=%0d, expected 0 0 0", busy, at_target, duty);
        end
        exp_q.push_back(8'd40);
        exp_q.push_back(8'd80);
        exp_q.push_back(8'd120);
        enable = 1'b1;
        wait_drain("enable_resume", 50);
        wait_hold("enable_resume", 10);
    endtask

    task automatic test_saturation();
        step = 8'd255;
        prescale = 16'd0;
        exp_q.push_back(8'd0);
        exp_q.push_back(8'd255);
        drive_cmd(8'd255, 1'b1);
        wait_drain("saturation", 50);
        @(negedge ACLK);
        vectors++;
        if (duty !== 8'd255 || dir !== 1'b1 || at_target !== 1'b1) begin
            miscompares++;
            $display("FAIL saturation: duty=%0d dir=%b at_target=%b, expected 255 1 1", duty, dir, at_target);
        end
    endtask

    task automatic test_async_reset();
        step = 8'd1;
        prescale = 16'd3;
        exp_q.push_back(8'd254);
        drive_cmd(8'd0, 1'b1);
        wait_drain("reset_setup", 50);
        exp_q.push_back(8'd0);
        #2 ARESETN = 1'b0;
        #1;
        vectors++;
        if ({duty, dir, busy, at_target, stopped} !== {8'd0, 4'b0000}) begin
            miscompares++;
            $display("FAIL async_reset: duty=%0d dir=%b busy=%b at_target=%b stopped=%b, expected all 0",
                     duty, dir, busy, at_target, stopped);
        end
        @(negedge ACLK);
        ARESETN = 1'b1;
        repeat (3) @(negedge ACLK);
        vectors++;
        if (busy !== 1'b0 || duty !== 8'd0) begin
            miscompares++;
            $display("FAIL post_reset_idle: busy=%b duty=%0d, expected 0 0", busy, duty);
        end
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_ramp_down_clamp();
        test_reversal();
        test_estop();
        test_enable_drop();
        test_saturation();
        test_async_reset();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_leftover: %0d expected duty values never seen", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
